// File: rtl/minmax_pkg.sv
// Shared state encoding and ordering helper for minmax_stream.
// Build option MINMAX_STREAM_COUNT_EN is consumed by the lane tree and the top.
package minmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int MM_MAXW = 32;

    // True when a strictly beats b on the low w bits. In signed mode the sign bit is flipped,
    // which maps two's complement order onto plain unsigned order.
    function automatic logic better(input logic [MM_MAXW-1:0] a,
                                    input logic [MM_MAXW-1:0] b,
                                    input int                 w,
                                    input logic               us,
                                    input logic               mx);
        logic [MM_MAXW-1:0] flip;
        logic [MM_MAXW-1:0] ax;
        logic [MM_MAXW-1:0] bx;
        flip = {{(MM_MAXW-1){1'b0}}, us} << (w - 1);
        ax   = a ^ flip;
        bx   = b ^ flip;
        return mx ? (ax > bx) : (ax < bx);
    endfunction

endpackage

// File: rtl/minmax_lane_tree.sv
// Combinational P-lane reduction: beat extreme, its lane (lowest lane on ties) and,
// with MINMAX_STREAM_COUNT_EN, how many lanes equal that extreme.
module minmax_lane_tree
    import minmax_pkg::*;
#(
    parameter int W  = 6,
    parameter int P  = 4,
    parameter int LW = (P > 1) ? $clog2(P) : 1
) (
    input  logic [P*W-1:0] i_data,
    input  logic           i_us,
    input  logic           i_mx,
    output logic [W-1:0]   o_value,
    output logic [LW-1:0]  o_lane
`ifdef MINMAX_STREAM_COUNT_EN
    ,
    output logic [$clog2(P+1)-1:0] o_count
`endif
);

    logic w_take;

    // Fold lanes upward from lane 0; a later lane replaces only on strict improvement.
    always_comb begin
        o_value = i_data[W-1:0];
        o_lane  = '0;
        w_take  = 1'b0;
        for (int k = 1; k < P; k++) begin
            w_take  = better(MM_MAXW'(i_data[k*W +: W]), MM_MAXW'(o_value), W, i_us, i_mx);
            o_value = w_take ? i_data[k*W +: W] : o_value;
            o_lane  = w_take ? LW'(k) : o_lane;
        end
    end

`ifdef MINMAX_STREAM_COUNT_EN
    localparam int CW = $clog2(P+1);

    // Number of lanes carrying the winning value.
    always_comb begin
        o_count = '0;
        for (int k = 0; k < P; k++) begin
            o_count = o_count + ((i_data[k*W +: W] == o_value) ? CW'(1) : CW'(0));
        end
    end
`endif

endmodule

// File: rtl/minmax_stream.sv
// Framed streaming min/max with frame-relative index and sticky overflow error.
// Define MINMAX_STREAM_COUNT_EN to add the m_count occurrence counter.
module minmax_stream
    import minmax_pkg::*;
#(
    parameter int W      = 6,
    parameter int P      = 4,
    parameter int MAXLEN = 16,
    parameter int IDXW   = $clog2(MAXLEN),
    parameter int CNTW   = $clog2(MAXLEN+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [P*W-1:0]  s_data,
    input  logic            s_last,
    input  logic            us_sel,
    input  logic            min_max_sel,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    m_result,
    output logic [IDXW-1:0] m_index,
    output logic            m_err
`ifdef MINMAX_STREAM_COUNT_EN
    ,
    output logic [CNTW-1:0] m_count
`endif
);

    localparam int LW    = (P > 1) ? $clog2(P) : 1;
    localparam int BEATS = MAXLEN / P;
    localparam int BW    = $clog2(BEATS + 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_us;
    logic            r_mx;
    logic [BW-1:0]   r_beat;
    logic            r_s1_valid;
    logic            r_s1_first;
    logic [W-1:0]    r_s1_value;
    logic [IDXW-1:0] r_s1_index;
    logic [W-1:0]    r_acc_value;
    logic [IDXW-1:0] r_acc_index;
    logic            r_err;

    logic            w_idle;
    logic            w_accept;
    logic [BW-1:0]   w_beat_num;
    logic            w_ovf;
    logic            w_us;
    logic            w_mx;
    logic [W-1:0]    w_tree_value;
    logic [LW-1:0]   w_tree_lane;
    logic            w_s1_wins;

    assign w_idle     = (r_state == ST_IDLE);
    assign s_ready    = ~rst & (w_idle | (r_state == ST_ACCUM));
    assign w_accept   = s_valid & s_ready;
    assign w_beat_num = w_idle ? BW'(0) : r_beat;
    assign w_ovf      = (w_beat_num >= BW'(BEATS));
    // The opening beat is reduced with the live mode inputs; later beats use the latched copy.
    assign w_us       = w_idle ? us_sel : r_us;
    assign w_mx       = w_idle ? min_max_sel : r_mx;
    assign w_s1_wins  = r_s1_first |
                        better(MM_MAXW'(r_s1_value), MM_MAXW'(r_acc_value), W, r_us, r_mx);

    assign m_valid  = (r_state == ST_HOLD);
    assign m_result = r_acc_value;
    assign m_index  = r_acc_index;
    assign m_err    = r_err;

`ifdef MINMAX_STREAM_COUNT_EN
    localparam int CW = $clog2(P+1);
    logic [CW-1:0]   w_tree_count;
    logic [CW-1:0]   r_s1_count;
    logic [CNTW-1:0] r_acc_count;
    assign m_count = r_acc_count;

    minmax_lane_tree #(.W(W), .P(P), .LW(LW)) u_tree (
        .i_data (s_data),
        .i_us   (w_us),
        .i_mx   (w_mx),
        .o_value(w_tree_value),
        .o_lane (w_tree_lane),
        .o_count(w_tree_count)
    );

    // Occurrence count: reload when the beat wins, add on a tie, otherwise keep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_count  <= '0;
            r_acc_count <= '0;
        end else begin
            r_s1_count <= w_accept ? w_tree_count : r_s1_count;
            if (r_s1_valid && w_s1_wins) begin
                r_acc_count <= CNTW'(r_s1_count);
            end else if (r_s1_valid && (r_s1_value == r_acc_value)) begin
                r_acc_count <= r_acc_count + CNTW'(r_s1_count);
            end else begin
                r_acc_count <= r_acc_count;
            end
        end
    end
`else
    minmax_lane_tree #(.W(W), .P(P), .LW(LW)) u_tree (
        .i_data (s_data),
        .i_us   (w_us),
        .i_mx   (w_mx),
        .o_value(w_tree_value),
        .o_lane (w_tree_lane)
    );
`endif

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame sequencing.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_accept ? (s_last ? ST_FLUSH : ST_ACCUM) : ST_IDLE;
            ST_ACCUM: w_next = (w_accept && s_last) ? ST_FLUSH : ST_ACCUM;
            ST_FLUSH: w_next = ST_HOLD;
            ST_HOLD:  w_next = m_ready ? ST_IDLE : ST_HOLD;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Mode latch, beat counter, stage-1 register and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_us       <= 1'b0;
            r_mx       <= 1'b0;
            r_beat     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_value <= '0;
            r_s1_index <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_us       <= w_us;
            r_mx       <= w_mx;
            r_beat     <= w_ovf ? w_beat_num : w_beat_num + BW'(1);
            r_s1_valid <= ~w_ovf;
            r_s1_first <= w_idle;
            r_s1_value <= w_tree_value;
            r_s1_index <= IDXW'(w_beat_num) * IDXW'(P) + IDXW'(w_tree_lane);
            r_err      <= w_idle ? 1'b0 : (r_err | w_ovf);
        end else begin
            r_s1_valid <= 1'b0;
        end
    end

    // Accumulator: the earliest index keeps ties because the beat must strictly improve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_value <= '0;
            r_acc_index <= '0;
        end else if (r_s1_valid && w_s1_wins) begin
            r_acc_value <= r_s1_value;
            r_acc_index <= r_s1_index;
        end else begin
            r_acc_value <= r_acc_value;
            r_acc_index <= r_acc_index;
        end
    end

endmodule

// File: tb/tb_minmax_stream.sv
// Directed and randomized frames for minmax_stream, checked against a queue-based reference.
`timescale 1ns/1ps
module tb_minmax_stream;

    localparam int W      = 6;
    localparam int P      = 4;
    localparam int MAXLEN = 16;
    localparam int IDXW   = 4;
    localparam int CNTW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic            us_sel = 1'b0;
    logic            min_max_sel = 1'b0;
    logic            m_ready = 1'b0;
    logic [P*W-1:0]  s_data = '0;
    logic            s_ready;
    logic            m_valid;
    logic            m_err;
    logic [W-1:0]    m_result;
    logic [IDXW-1:0] m_index;
`ifdef MINMAX_STREAM_COUNT_EN
    logic [CNTW-1:0] m_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] frame_q[$];

    always #5 clk = ~clk;

    minmax_stream #(.W(W), .P(P), .MAXLEN(MAXLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .us_sel     (us_sel),
        .min_max_sel(min_max_sel),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_result   (m_result),
        .m_index    (m_index),
        .m_err      (m_err)
`ifdef MINMAX_STREAM_COUNT_EN
        ,
        .m_count    (m_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P*W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    function automatic int val(input logic [W-1:0] x, input logic us);
        return us ? int'($signed(x)) : int'(x);
    endfunction

    // Reference: scan the first MAXLEN samples in index order, strict improvement only.
    task automatic model(input logic us, input logic mx, output logic [W-1:0] r,
                         output logic [IDXW-1:0] idx, output logic err, output logic [CNTW-1:0] cnt);
        int n, bi, best, c;
        n    = (frame_q.size() > MAXLEN) ? MAXLEN : frame_q.size();
        bi   = 0;
        best = val(frame_q[0], us);
        for (int i = 1; i < n; i++) begin
            if (mx ? (val(frame_q[i], us) > best) : (val(frame_q[i], us) < best)) begin
                best = val(frame_q[i], us);
                bi   = i;
            end
        end
        c = 0;
        for (int i = 0; i < n; i++) c += (val(frame_q[i], us) == best) ? 1 : 0;
        r   = frame_q[bi];
        idx = IDXW'(bi);
        err = (frame_q.size() > MAXLEN);
        cnt = CNTW'(c);
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input logic [P*W-1:0] d, input logic last, input logic us,
                             input logic mx, input int gap);
        s_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            us_sel      = ~us_sel;
            min_max_sel = ~min_max_sel;
            @(negedge clk);
        end
        s_valid = 1'b1; s_data = d; s_last = last; us_sel = us; min_max_sel = mx;
        for (int n = 0; n < 20 && s_ready !== 1'b1; n++) @(negedge clk);
        check("s_ready_at_beat", s_ready, 1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int k = 0; k < P; k++) frame_q.push_back(d[k*W +: W]);
    endtask

    // Called right after the closing beat; checks FLUSH latency, result, hold stability, handshake.
    task automatic expect_result(input string tag, input logic [W-1:0] er, input logic [IDXW-1:0] ei,
                                 input logic ee, input logic [CNTW-1:0] ec, input int hold);
        check({tag, "_flush_mvalid"}, m_valid, 0);
        check({tag, "_flush_sready"}, s_ready, 0);
        @(negedge clk);
        check({tag, "_mvalid"}, m_valid, 1);
        check({tag, "_result"}, m_result, er);
        check({tag, "_index"}, m_index, ei);
        check({tag, "_err"}, m_err, ee);
`ifdef MINMAX_STREAM_COUNT_EN
        check({tag, "_count"}, m_count, ec);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_mvalid"}, m_valid, 1);
            check({tag, "_hold_sready"}, s_ready, 0);
            check({tag, "_hold_result"}, m_result, er);
            check({tag, "_hold_index"}, m_index, ei);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_after_mvalid"}, m_valid, 0);
        check({tag, "_after_sready"}, s_ready, 1);
        frame_q.delete();
    endtask

    initial begin
        logic [W-1:0]    er;
        logic [IDXW-1:0] ei;
        logic            ee;
        logic [CNTW-1:0] ec;
        logic            us, mx;
        logic [P*W-1:0]  d;
        int              nb;

        // Reset state
        @(negedge clk);
        check("rst_sready", s_ready, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_result", m_result, 0);
        check("rst_index", m_index, 0);
        check("rst_err", m_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_sready", s_ready, 1);

        // Unsigned max over two beats with a tie inside the first beat
        send_beat(pack(3, 9, 9, 1), 1'b0, 1'b0, 1'b1, 0);
        send_beat(pack(0, 5, 2, 7), 1'b1, 1'b0, 1'b1, 0);
        expect_result("umax", 6'd9, 4'd1, 1'b0, 5'd2, 0);

        // Signed min, single beat, held 5 cycles under backpressure
        send_beat(pack(5, 32, 63, 32), 1'b1, 1'b1, 1'b0, 0);
        expect_result("smin", 6'h20, 4'd1, 1'b0, 5'd2, 5);

        // Overflow: 63 only at sample 18, beyond MAXLEN
        for (int b = 0; b < 5; b++)
            send_beat((b == 4) ? pack(1, 1, 63, 1) : pack(1, 1, 1, 1), b == 4, 1'b0, 1'b1, 0);
        expect_result("ovf", 6'd1, 4'd0, 1'b1, 5'd16, 0);

        // Reset mid-frame, then a fresh frame
        send_beat(pack(60, 61, 62, 63), 1'b0, 1'b0, 1'b1, 0);
        send_beat(pack(63, 63, 63, 63), 1'b0, 1'b0, 1'b1, 0);
        frame_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sready", s_ready, 0);
        check("midrst_result", m_result, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_stale", m_valid, 0);
        end
        send_beat(pack(4, 4, 8, 2), 1'b1, 1'b0, 1'b1, 0);
        expect_result("post_rst", 6'd8, 4'd2, 1'b0, 5'd1, 0);

        // Mode flips on the second beat are ignored: result stays a minimum
        send_beat(pack(10, 20, 30, 40), 1'b0, 1'b0, 1'b0, 0);
        send_beat(pack(5, 50, 60, 2), 1'b1, 1'b1, 1'b1, 0);
        expect_result("mode_chg", 6'd2, 4'd7, 1'b0, 5'd1, 0);

        // Randomized frames, including stalls, narrow-range ties and overflow
        for (int f = 0; f < 30; f++) begin
            nb = $urandom_range(1, 5);
            us = 1'($urandom_range(0, 1));
            mx = 1'($urandom_range(0, 1));
            for (int b = 0; b < nb; b++) begin
                if (f % 2 == 0) begin
                    for (int k = 0; k < P; k++) d[k*W +: W] = W'($urandom_range(0, 3) + ((f % 4 == 0) ? 30 : 0));
                end else begin
                    d = (P*W)'($urandom);
                end
                send_beat(d, b == nb - 1, (b == 0) ? us : 1'($urandom), (b == 0) ? mx : 1'($urandom),
                          (b == 0) ? 0 : $urandom_range(0, 2));
            end
            model(us, mx, er, ei, ee, ec);
            expect_result("rand", er, ei, ee, ec, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
